// File: rtl/channel_dma.sv
// channel_dma: byte-stream <-> word-wide AXI4-Lite DMA engine with byte packing and strobes.
// Optional AXI transaction counter on axi_txns is built when CHANNEL_DMA_TXN_COUNT_EN is defined.
module channel_dma #(
    parameter int ADDR_W  = 32,
    parameter int COUNT_W = 16,
    parameter int DATA_W  = 64
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  start,
    input  logic                  dir,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [COUNT_W-1:0]    count,
    input  logic                  stop,
    input  logic                  flush,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [COUNT_W-1:0]    residual,
    output logic [7:0]            send_tdata,
    output logic                  send_tvalid,
    input  logic                  send_tready,
    input  logic [7:0]            recv_tdata,
    input  logic                  recv_tvalid,
    output logic                  recv_tready,
    output logic [ADDR_W-1:0]     m_axi_araddr,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_W-1:0]     m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    output logic [ADDR_W-1:0]     m_axi_awaddr,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_W-1:0]     m_axi_wdata,
    output logic [DATA_W/8-1:0]   m_axi_wstrb,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [31:0]           axi_txns
);

    localparam int BYTES = DATA_W / 8;
    localparam int LW    = $clog2(BYTES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SEND,
        ST_COLLECT,
        ST_WRITE,
        ST_FIN
    } state_t;

    state_t               state_q, state_d;
    logic                 dir_q, dir_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [ADDR_W-1:0]    waddr_q, waddr_d;
    logic [COUNT_W-1:0]   residual_q, residual_d;
    logic [DATA_W-1:0]    buf_q, buf_d;
    logic [BYTES-1:0]     strb_q, strb_d;
    logic                 term_q, term_d;
    logic                 error_q, error_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
    logic                 send_tvalid_q, send_tvalid_d;
    logic                 recv_tready_q, recv_tready_d;
    logic                 arvalid_q, arvalid_d;
    logic                 rready_q, rready_d;
    logic                 awvalid_q, awvalid_d;
    logic                 wvalid_q, wvalid_d;
    logic                 bready_q, bready_d;

    logic [LW-1:0]        lane;
    logic [BYTES-1:0]     lane_oh;
    logic [BYTES-1:0]     strb_new;
    logic [7:0]           send_byte;
    logic                 send_hs, recv_hs, r_hs, b_hs;
    logic                 lane_last, last_byte, term_in;
    logic [ADDR_W-1:0]    word_addr;

    assign lane      = addr_q[LW-1:0];
    assign word_addr = {addr_q[ADDR_W-1:LW], {LW{1'b0}}};
    assign send_hs   = send_tvalid_q & send_tready;
    assign recv_hs   = recv_tready_q & recv_tvalid;
    assign r_hs      = rready_q & m_axi_rvalid;
    assign b_hs      = bready_q & m_axi_bvalid;
    assign lane_last = (lane == LW'(BYTES - 1));
    assign last_byte = (residual_q == COUNT_W'(1));
    // flush only means something while collecting from the channel
    assign term_in   = stop | (flush & dir_q);

    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_lane
            assign lane_oh[gi] = (lane == LW'(gi));
        end
    endgenerate

    always_comb begin
        send_byte = '0;
        for (int i = 0; i < BYTES; i++) begin
            if (lane_oh[i]) send_byte = buf_q[i*8 +: 8];
        end
    end

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        addr_d     = addr_q;
        waddr_d    = waddr_q;
        residual_d = residual_q;
        buf_d      = buf_q;
        strb_d     = strb_q;
        term_d     = term_q;
        error_d    = error_q;
        done_d     = 1'b0;
        busy_d     = busy_q;
        arvalid_d  = arvalid_q;
        rready_d   = rready_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        bready_d   = bready_q;
        strb_new   = strb_q;

        if (busy_q && term_in) term_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dir_d      = dir;
                    addr_d     = addr;
                    residual_d = count;
                    error_d    = 1'b0;
                    term_d     = 1'b0;
                    strb_d     = '0;
                    busy_d     = 1'b1;
                    if (count == '0)  state_d = ST_FIN;
                    else if (dir)     state_d = ST_COLLECT;
                    else              state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                if (arvalid_q && m_axi_arready) arvalid_d = 1'b0;
                if (r_hs) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b0;
                    buf_d     = m_axi_rdata;
                    if (m_axi_rresp != 2'b00) begin
                        error_d = 1'b1;
                        state_d = ST_FIN;
                    end else if (term_q || term_in) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_SEND;
                    end
                end
            end

            ST_SEND: begin
                if (send_hs && residual_q != '0) begin
                    addr_d     = addr_q + ADDR_W'(1);
                    residual_d = residual_q - COUNT_W'(1);
                end
                if (stop || (send_hs && last_byte)) state_d = ST_FIN;
                else if (send_hs && lane_last)      state_d = ST_FETCH;
            end

            ST_COLLECT: begin
                if (recv_hs && residual_q != '0) begin
                    for (int i = 0; i < BYTES; i++) begin
                        if (lane_oh[i]) buf_d[i*8 +: 8] = recv_tdata;
                    end
                    strb_new   = strb_q | lane_oh;
                    addr_d     = addr_q + ADDR_W'(1);
                    residual_d = residual_q - COUNT_W'(1);
                end
                strb_d = strb_new;
                // the word being closed is always the one addr_q points into
                if ((recv_hs && (lane_last || last_byte)) || term_in || term_q) begin
                    waddr_d = word_addr;
                    state_d = (strb_new == '0) ? ST_FIN : ST_WRITE;
                end
            end

            ST_WRITE: begin
                if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
                if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
                if (b_hs) begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b0;
                    bready_d  = 1'b0;
                    if (m_axi_bresp != 2'b00) begin
                        error_d = 1'b1;
                        state_d = ST_FIN;
                    end else begin
                        strb_d = '0;
                        if (residual_q == '0 || term_q || term_in) state_d = ST_FIN;
                        else                                       state_d = ST_COLLECT;
                    end
                end
            end

            ST_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_FETCH && state_q != ST_FETCH) begin
            arvalid_d = 1'b1;
            rready_d  = 1'b1;
        end
        if (state_d == ST_WRITE && state_q != ST_WRITE) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            bready_d  = 1'b1;
        end
        send_tvalid_d = (state_d == ST_SEND);
        recv_tready_d = (state_d == ST_COLLECT);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q       <= ST_IDLE;
            dir_q         <= 1'b0;
            addr_q        <= '0;
            waddr_q       <= '0;
            residual_q    <= '0;
            buf_q         <= '0;
            strb_q        <= '0;
            term_q        <= 1'b0;
            error_q       <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
            send_tvalid_q <= 1'b0;
            recv_tready_q <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            dir_q         <= dir_d;
            addr_q        <= addr_d;
            waddr_q       <= waddr_d;
            residual_q    <= residual_d;
            buf_q         <= buf_d;
            strb_q        <= strb_d;
            term_q        <= term_d;
            error_q       <= error_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
            send_tvalid_q <= send_tvalid_d;
            recv_tready_q <= recv_tready_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            bready_q      <= bready_d;
        end
    end

`ifdef CHANNEL_DMA_TXN_COUNT_EN
    logic [31:0] txns_q;

    always_ff @(posedge aclk) begin
        if (!aresetn)                       txns_q <= '0;
        else if (state_q == ST_IDLE && start) txns_q <= '0;
        else if (r_hs || b_hs)              txns_q <= txns_q + 32'd1;
    end

    assign axi_txns = txns_q;
`else
    assign axi_txns = '0;
`endif

    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign residual      = residual_q;
    assign send_tdata    = send_byte;
    assign send_tvalid   = send_tvalid_q;
    assign recv_tready   = recv_tready_q;
    assign m_axi_araddr  = word_addr;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;
    assign m_axi_awaddr  = waddr_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = buf_q;
    assign m_axi_wstrb   = strb_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;

endmodule

// File: tb/tb_channel_dma.sv
// Directed bench for channel_dma: table of transfers plus hand sequences for flush, error, stop and zero count.
module tb_channel_dma;

    localparam int ADDR_W  = 32;
    localparam int COUNT_W = 16;
    localparam int DATA_W  = 64;

    logic              aclk, aresetn, start, dir, stop, flush;
    logic [31:0]       addr;
    logic [15:0]       count;
    logic              busy, done, error;
    logic [15:0]       residual;
    logic [7:0]        send_tdata, recv_tdata;
    logic              send_tvalid, send_tready, recv_tvalid, recv_tready;
    logic [31:0]       m_axi_araddr, m_axi_awaddr;
    logic              m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;
    logic [63:0]       m_axi_rdata, m_axi_wdata;
    logic [1:0]        m_axi_rresp, m_axi_bresp;
    logic              m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [7:0]        m_axi_wstrb;
    logic              m_axi_bvalid, m_axi_bready;
    logic [31:0]       axi_txns;

    channel_dma #(.ADDR_W(ADDR_W), .COUNT_W(COUNT_W), .DATA_W(DATA_W)) dut (
        .aclk(aclk), .aresetn(aresetn), .start(start), .dir(dir), .addr(addr), .count(count),
        .stop(stop), .flush(flush), .busy(busy), .done(done), .error(error), .residual(residual),
        .send_tdata(send_tdata), .send_tvalid(send_tvalid), .send_tready(send_tready),
        .recv_tdata(recv_tdata), .recv_tvalid(recv_tvalid), .recv_tready(recv_tready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready), .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .axi_txns(axi_txns)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_cmp = 0;
    int n_bad = 0;

    // Memory model: unwritten words read back a fixed address-derived pattern.
    logic [63:0] mem [logic [31:0]];
    logic [31:0] ar_log[$];
    logic [31:0] aw_log[$];
    logic [7:0]  aw_strb_log[$];
    logic [63:0] w_data_log[$];
    logic [7:0]  tx_log[$];
    logic [7:0]  rx_q[$];
    int          ar_stall = 0;
    int          bad_ar_idx = -1;

    function automatic logic [7:0] pat(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [63:0] rd_word(input logic [31:0] wa);
        logic [63:0] w;
        if (mem.exists(wa)) return mem[wa];
        for (int i = 0; i < 8; i++) w[i*8 +: 8] = pat(wa + 32'(i));
        return w;
    endfunction

    task automatic tick();
        @(negedge aclk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // AXI slave and stream endpoints, evaluated on the falling edge from values seen a cycle earlier.
    initial begin
        logic        p_arv, p_arr, p_rv, p_rr, p_awv, p_awr, p_wv, p_wr, p_bv, p_br;
        logic        p_stv, p_str, p_rtv, p_rtr, rd_pend, aw_got, w_got;
        logic [31:0] p_araddr, p_awaddr, rd_addr, aw_a;
        logic [63:0] p_wdata, w_d, wv;
        logic [7:0]  p_wstrb, w_s, p_std;
        {p_arv, p_arr, p_rv, p_rr, p_awv, p_awr, p_wv, p_wr, p_bv, p_br} = '0;
        {p_stv, p_str, p_rtv, p_rtr, rd_pend, aw_got, w_got} = '0;
        p_araddr = '0; p_awaddr = '0; rd_addr = '0; aw_a = '0;
        p_wdata = '0; w_d = '0; p_wstrb = '0; w_s = '0; p_std = '0;
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rresp = 0;
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
        recv_tvalid = 0; recv_tdata = '0;
        forever begin
            @(negedge aclk);
            if (p_arv && p_arr) begin ar_log.push_back(p_araddr); rd_addr = p_araddr; rd_pend = 1; end
            if (p_rv && p_rr) m_axi_rvalid = 0;
            if (rd_pend) begin
                m_axi_rvalid = 1;
                m_axi_rdata  = rd_word(rd_addr);
                m_axi_rresp  = (ar_log.size() - 1 == bad_ar_idx) ? 2'd2 : 2'd0;
                rd_pend = 0;
            end
            if (p_awv && p_awr) begin aw_log.push_back(p_awaddr); aw_a = p_awaddr; aw_got = 1; end
            if (p_wv && p_wr) begin w_d = p_wdata; w_s = p_wstrb; w_got = 1; end
            if (p_bv && p_br) m_axi_bvalid = 0;
            if (aw_got && w_got) begin
                aw_strb_log.push_back(w_s);
                w_data_log.push_back(w_d);
                wv = rd_word(aw_a);
                for (int i = 0; i < 8; i++) if (w_s[i]) wv[i*8 +: 8] = w_d[i*8 +: 8];
                mem[aw_a] = wv;
                m_axi_bvalid = 1; m_axi_bresp = 0;
                aw_got = 0; w_got = 0;
            end
            if (p_stv && p_str) tx_log.push_back(p_std);
            if (p_rtv && p_rtr) void'(rx_q.pop_front());
            if (m_axi_arvalid && ar_stall > 0) begin ar_stall--; m_axi_arready = 0; end
            else m_axi_arready = m_axi_arvalid;
            m_axi_awready = m_axi_awvalid;
            m_axi_wready  = m_axi_wvalid;
            recv_tvalid   = (rx_q.size() > 0);
            recv_tdata    = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
            p_arv = m_axi_arvalid; p_arr = m_axi_arready; p_araddr = m_axi_araddr;
            p_rv  = m_axi_rvalid;  p_rr  = m_axi_rready;
            p_awv = m_axi_awvalid; p_awr = m_axi_awready; p_awaddr = m_axi_awaddr;
            p_wv  = m_axi_wvalid;  p_wr  = m_axi_wready;  p_wdata = m_axi_wdata; p_wstrb = m_axi_wstrb;
            p_bv  = m_axi_bvalid;  p_br  = m_axi_bready;
            p_stv = send_tvalid;   p_str = send_tready;   p_std = send_tdata;
            p_rtv = recv_tvalid;   p_rtr = recv_tready;
        end
    end

    typedef struct {
        logic        dir;
        logic [31:0] addr;
        logic [15:0] count;
        int          n_rx;
        logic [15:0] res;
        logic        err;
        int          nar;
        int          naw;
        logic [31:0] a0;
        logic [7:0]  s0;
        logic [31:0] a1;
        logic [7:0]  s1;
    } vec_t;

    task automatic clear_logs();
        ar_log.delete(); aw_log.delete(); aw_strb_log.delete();
        w_data_log.delete(); tx_log.delete(); rx_q.delete();
    endtask

    task automatic start_xfer(input logic d, input logic [31:0] a, input logic [15:0] c);
        dir = d; addr = a; count = c; start = 1;
        tick();
        start = 0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        bit got = 0;
        for (int i = 0; i < budget && !got; i++) begin
            tick();
            if (done) got = 1;
        end
        chk({tag, ".done_seen"}, 64'(got), 64'(1));
    endtask

    task automatic check_result(input vec_t v, input string tag);
        int exp_txn;
        chk({tag, ".residual"}, 64'(residual), 64'(v.res));
        chk({tag, ".error"}, 64'(error), 64'(v.err));
        chk({tag, ".busy_at_done"}, 64'(busy), 64'(0));
        tick(); tick();
        chk({tag, ".n_ar"}, 64'(ar_log.size()), 64'(v.nar));
        chk({tag, ".n_aw"}, 64'(aw_log.size()), 64'(v.naw));
        if (v.nar > 0 && ar_log.size() > 0) chk({tag, ".ar0"}, 64'(ar_log[0]), 64'(v.a0));
        if (v.nar > 1 && ar_log.size() > 1) chk({tag, ".ar1"}, 64'(ar_log[1]), 64'(v.a1));
        if (v.naw > 0 && aw_log.size() > 0) begin
            chk({tag, ".aw0"}, 64'(aw_log[0]), 64'(v.a0));
            chk({tag, ".wstrb0"}, 64'(aw_strb_log[0]), 64'(v.s0));
        end
        if (v.naw > 1 && aw_log.size() > 1) begin
            chk({tag, ".aw1"}, 64'(aw_log[1]), 64'(v.a1));
            chk({tag, ".wstrb1"}, 64'(aw_strb_log[1]), 64'(v.s1));
        end
        chk({tag, ".n_sent"}, 64'(tx_log.size()), (v.dir == 1'b0) ? 64'(v.count - v.res) : 64'(0));
        for (int i = 0; i < tx_log.size(); i++)
            chk($sformatf("%s.sent%0d", tag, i), 64'(tx_log[i]), 64'(pat(v.addr + 32'(i))));
        for (int k = 0; k < aw_log.size() && k < w_data_log.size(); k++) begin
            for (int l = 0; l < 8; l++) begin
                if (aw_strb_log[k][l]) begin
                    logic [31:0] off;
                    off = aw_log[k] + 32'(l) - v.addr;
                    chk($sformatf("%s.w%0d.lane%0d", tag, k, l), 64'(w_data_log[k][l*8 +: 8]),
                        64'(8'(8'hA0 + off[7:0])));
                end
            end
        end
`ifdef CHANNEL_DMA_TXN_COUNT_EN
        exp_txn = v.nar + v.naw;
`else
        exp_txn = 0;
`endif
        chk({tag, ".axi_txns"}, 64'(axi_txns), 64'(exp_txn));
        $display("xfer %s: dir=%0d addr=0x%0h count=%0d residual=%0d error=%0d ar=%0d aw=%0d sent=%0d",
                 tag, v.dir, v.addr, v.count, residual, error, ar_log.size(), aw_log.size(), tx_log.size());
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        clear_logs();
        for (int i = 0; i < v.n_rx; i++) rx_q.push_back(8'(8'hA0 + i));
        start_xfer(v.dir, v.addr, v.count);
        wait_done(400, tag);
        check_result(v, tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vt[6];
        vec_t v;
        bit   hit;
        //         dir  addr      cnt n_rx res err nar naw a0        s0     a1        s1
        vt[0] = '{1'b0, 32'h1003, 6,  0,   0,  0,  2,  0,  32'h1000, 8'h00, 32'h1008, 8'h00};
        vt[1] = '{1'b1, 32'h2006, 4,  4,   0,  0,  0,  2,  32'h2000, 8'hC0, 32'h2008, 8'h03};
        vt[2] = '{1'b0, 32'h0040, 8,  0,   0,  0,  1,  0,  32'h0040, 8'h00, 32'h0000, 8'h00};
        vt[3] = '{1'b1, 32'h0105, 3,  3,   0,  0,  0,  1,  32'h0100, 8'hE0, 32'h0000, 8'h00};
        vt[4] = '{1'b1, 32'h0200, 10, 10,  0,  0,  0,  2,  32'h0200, 8'hFF, 32'h0208, 8'h03};
        vt[5] = '{1'b0, 32'h7000, 0,  0,   0,  0,  0,  0,  32'h0000, 8'h00, 32'h0000, 8'h00};

        aresetn = 0; start = 0; dir = 0; addr = '0; count = '0; stop = 0; flush = 0; send_tready = 1;
        repeat (3) tick();
        chk("reset.busy", 64'(busy), 64'(0));
        chk("reset.done", 64'(done), 64'(0));
        chk("reset.error", 64'(error), 64'(0));
        chk("reset.residual", 64'(residual), 64'(0));
        chk("reset.valids", 64'({send_tvalid, recv_tready, m_axi_arvalid, m_axi_rready,
                                 m_axi_awvalid, m_axi_wvalid, m_axi_bready}), 64'(0));
        chk("reset.axi_txns", 64'(axi_txns), 64'(0));
        aresetn = 1;
        tick();

        flush = 1; tick(); flush = 0; tick();
        chk("idle_flush.busy", 64'(busy), 64'(0));
        chk("idle_flush.done", 64'(done), 64'(0));

        for (int i = 0; i < 6; i++) run_vec(vt[i], $sformatf("row%0d", i));

        // Early flush from the channel after three bytes.
        clear_logs();
        for (int i = 0; i < 3; i++) rx_q.push_back(8'(8'hA0 + i));
        start_xfer(1'b1, 32'h3000, 16'd20);
        hit = 0;
        for (int i = 0; i < 50 && !hit; i++) begin tick(); if (residual == 16'd17) hit = 1; end
        chk("flush.reach_17", 64'(hit), 64'(1));
        tick(); tick();
        flush = 1; tick(); flush = 0;
        wait_done(200, "flush");
        v = '{1'b1, 32'h3000, 20, 3, 17, 1'b0, 0, 1, 32'h3000, 8'h07, 32'h0, 8'h00};
        check_result(v, "flush");

        // Bad read response on the second word ends the send with error.
        bad_ar_idx = 1;
        v = '{1'b0, 32'h4000, 16, 0, 8, 1'b1, 2, 0, 32'h4000, 8'h00, 32'h4008, 8'h00};
        run_vec(v, "rerr");
        bad_ar_idx = -1;

        // Stop while AR is stalled; a second start during the transfer is ignored.
        clear_logs();
        ar_stall = 5;
        start_xfer(1'b0, 32'h5000, 16'd5);
        chk("stopf.error_cleared", 64'(error), 64'(0));
        tick();
        stop = 1; tick(); stop = 0;
        dir = 1; addr = 32'h6000; count = 16'd9; start = 1; tick(); start = 0;
        chk("stopf.busy", 64'(busy), 64'(1));
        wait_done(200, "stopf");
        v = '{1'b0, 32'h5000, 5, 0, 5, 1'b0, 1, 0, 32'h5000, 8'h00, 32'h0, 8'h00};
        check_result(v, "stopf");

        // Stop in the same cycle as the first send handshake: that byte still counts.
        clear_logs();
        start_xfer(1'b0, 32'h9000, 16'd8);
        hit = 0;
        for (int i = 0; i < 50 && !hit; i++) begin if (send_tvalid) hit = 1; else tick(); end
        chk("stops.tvalid_seen", 64'(hit), 64'(1));
        stop = 1; tick(); stop = 0;
        wait_done(50, "stops");
        v = '{1'b0, 32'h9000, 8, 0, 7, 1'b0, 1, 0, 32'h9000, 8'h00, 32'h0, 8'h00};
        check_result(v, "stops");

        // Zero count: done exactly two cycles after the start pulse, with no bus traffic.
        clear_logs();
        start_xfer(1'b1, 32'h7100, 16'd0);
        chk("zero.done_c1", 64'(done), 64'(0));
        chk("zero.busy_c1", 64'(busy), 64'(1));
        tick();
        chk("zero.done_c2", 64'(done), 64'(1));
        chk("zero.busy_c2", 64'(busy), 64'(0));
        tick();
        chk("zero.done_c3", 64'(done), 64'(0));
        chk("zero.axi", 64'(ar_log.size() + aw_log.size()), 64'(0));
        chk("zero.axi_txns", 64'(axi_txns), 64'(0));
        $display("xfer zero: dir=1 addr=0x7100 count=0 residual=%0d error=%0d", residual, error);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
